// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, register address,
// requester indices and the canned response bytes sent by the command block.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_LOAD        = 2'd1,
      ST_WAIT_ACCEPT = 2'd2,
      ST_WAIT_DONE   = 2'd3
   } tx_state_e;

   localparam logic [2:0] UART_REG_DATA = 3'b000;

   localparam int REQ_ACK     = 0;
   localparam int REQ_REACHED = 1;
   localparam int REQ_STATE   = 2;
   localparam int REQ_ERR     = 3;

   localparam logic [7:0] RESP_ACK     = "A";
   localparam logic [7:0] RESP_REACHED = "R";
   localparam logic [7:0] RESP_UNKNOWN = "?";

   // Index width that stays legal for a single requester.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational winner selection over the pending slots; fixed priority scans from
// index 0, round-robin scans from the pointer and wraps.
module rr_priority_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [IDX_W-1:0]   pointer,
   input  logic               rr_en,
   output logic [NUM_REQ-1:0] winner_onehot,
   output logic [IDX_W-1:0]   winner_idx,
   output logic               winner_valid
);

   int               start;
   int               cand;
   logic [IDX_W-1:0] cand_idx;

   always_comb begin
      winner_onehot = '0;
      winner_idx    = '0;
      winner_valid  = 1'b0;
      cand          = 0;
      cand_idx      = '0;
      start         = rr_en ? int'(pointer) : 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = start + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!winner_valid && pending[cand_idx]) begin
            winner_valid            = 1'b1;
            winner_idx              = cand_idx;
            winner_onehot[cand_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART_MASTER transmit channel between byte sources, each with a one-deep
// holding slot, and sequences the write handshake against TxRDYn.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int RR_EN          = 0,
   parameter int ACCEPT_TIMEOUT = 64,
   parameter int CNT_W          = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   drop,
   output logic [CNT_W-1:0]     drop_count,
   output logic                 busy,
   output logic                 tx_en,
   output logic [2:0]           waddr,
   output logic [7:0]           wdata,
   input  logic                 tx_rdy_n
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int TO_W  = $clog2(ACCEPT_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACCEPT_TIMEOUT - 1);

   tx_state_e                 state_q;
   logic [NUM_REQ-1:0]        slot_full_q, slot_full_d;
   logic [NUM_REQ-1:0][7:0]   slot_data_q, slot_data_d;
   logic [NUM_REQ-1:0]        drop_q, drop_d;
   logic [CNT_W-1:0]          drop_count_q, drop_count_d;
   logic [IDX_W-1:0]          win_idx_q;
   logic [NUM_REQ-1:0]        win_onehot_q;
   logic [IDX_W-1:0]          rr_ptr_q;
   logic [NUM_REQ-1:0]        grant_q;
   logic                      tx_en_q;
   logic                      busy_q;
   logic [7:0]                wdata_q;
   logic [TO_W-1:0]           timeout_cnt_q;

   logic [NUM_REQ-1:0]        pick_onehot;
   logic [IDX_W-1:0]          pick_idx;
   logic                      pick_valid;
   logic [NUM_REQ-1:0]        slot_clear;
   logic [IDX_W-1:0]          next_ptr;

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .pending       (slot_full_q),
      .pointer       (rr_ptr_q),
      .rr_en         (RR_EN != 0),
      .winner_onehot (pick_onehot),
      .winner_idx    (pick_idx),
      .winner_valid  (pick_valid)
   );

   // The winner slot empties on the LOAD edge, so a request landing then is accepted.
   assign slot_clear = (state_q == ST_LOAD) ? win_onehot_q : '0;
   assign next_ptr   = (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + IDX_W'(1);

   always_comb begin
      slot_full_d  = slot_full_q & ~slot_clear;
      slot_data_d  = slot_data_q;
      drop_d       = '0;
      drop_count_d = drop_count_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i]) begin
            if (slot_full_d[i]) begin
               drop_d[i] = 1'b1;
            end else begin
               slot_full_d[i] = 1'b1;
               slot_data_d[i] = req_data[i*8 +: 8];
            end
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (drop_d[i] && (drop_count_d != {CNT_W{1'b1}})) begin
            drop_count_d = drop_count_d + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         slot_full_q  <= '0;
         slot_data_q  <= '0;
         drop_q       <= '0;
         drop_count_q <= '0;
      end else begin
         slot_full_q  <= slot_full_d;
         slot_data_q  <= slot_data_d;
         drop_q       <= drop_d;
         drop_count_q <= drop_count_d;
      end
   end

   // The winner is latched on leaving IDLE and stays fixed through LOAD.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         win_idx_q     <= '0;
         win_onehot_q  <= '0;
         rr_ptr_q      <= '0;
         grant_q       <= '0;
         tx_en_q       <= 1'b0;
         busy_q        <= 1'b0;
         wdata_q       <= '0;
         timeout_cnt_q <= '0;
      end else begin
         grant_q <= '0;
         tx_en_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pick_valid && !tx_rdy_n) begin
                  win_idx_q    <= pick_idx;
                  win_onehot_q <= pick_onehot;
                  state_q      <= ST_LOAD;
                  busy_q       <= 1'b1;
               end
            end
            ST_LOAD: begin
               tx_en_q       <= 1'b1;
               grant_q       <= win_onehot_q;
               wdata_q       <= slot_data_q[win_idx_q];
               timeout_cnt_q <= '0;
               state_q       <= ST_WAIT_ACCEPT;
               if (RR_EN != 0) begin
                  rr_ptr_q <= next_ptr;
               end
            end
            ST_WAIT_ACCEPT: begin
               if (tx_rdy_n || (timeout_cnt_q == TO_LAST)) begin
                  state_q <= ST_WAIT_DONE;
               end else begin
                  timeout_cnt_q <= timeout_cnt_q + TO_W'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_rdy_n) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign grant      = grant_q;
   assign drop       = drop_q;
   assign drop_count = drop_count_q;
   assign busy       = busy_q;
   assign tx_en      = tx_en_q;
   assign waddr      = UART_REG_DATA;
   assign wdata      = wdata_q;

endmodule
